// File: rtl/llc_mem_responder_pkg.sv
// Shared defaults, types and helpers for the LLC memory-side responder.
// Defaults match the LLC build's memory channel: 128-bit lines, 28-bit line addresses.
package llc_mem_responder_pkg;

    localparam int MEM_RSP_LATENCY    = 4;
    localparam int MEM_DEPTH          = 1024;
    localparam int MEM_LINE_ADDR_BITS = 28;
    localparam int MEM_LINE_BITS      = 128;

    typedef logic [MEM_LINE_ADDR_BITS-1:0] line_addr_t;
    typedef logic [MEM_LINE_BITS-1:0]      line_t;
    typedef logic [1:0]                    hprot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } mem_state_t;

    // Width of the wait counter. It is never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return ($clog2(latency) < 1) ? 1 : $clog2(latency);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/llc_mem_array.sv
// Backing store for the responder: line storage with one write port and one
// combinational read port. It also keeps a per-line valid vector with an async clear.
module llc_mem_array #(
    parameter int DEPTH     = 1024,
    parameter int LINE_BITS = 128,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic [LINE_BITS-1:0] rd_line,
    output logic                 rd_valid
);

    logic [LINE_BITS-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     line_valid;

    // NOTE: the data array has no reset so it can map to RAM; line_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_line;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            line_valid <= '0;
        else if (wr_en)
            line_valid[wr_idx] <= 1'b1;
    end

    assign rd_line  = mem[rd_idx];
    assign rd_valid = line_valid[rd_idx];

endmodule

// File: rtl/llc_mem_responder.sv
// Memory endpoint for the LLC request/response channel. It serves full-line writes,
// and full-line reads after a fixed latency, with at most one read outstanding.
module llc_mem_responder
    import llc_mem_responder_pkg::*;
#(
    parameter int LINE_ADDR_BITS = MEM_LINE_ADDR_BITS,
    parameter int LINE_BITS      = MEM_LINE_BITS,
    parameter int DEPTH          = MEM_DEPTH,
    parameter int LATENCY        = MEM_RSP_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      llc_mem_req_valid,
    output logic                      llc_mem_req_ready,
    input  logic                      llc_mem_req_hwrite,
    input  logic [2:0]                llc_mem_req_hsize,
    input  logic [1:0]                llc_mem_req_hprot,
    input  logic [LINE_ADDR_BITS-1:0] llc_mem_req_addr,
    input  logic [LINE_BITS-1:0]      llc_mem_req_line,
    output logic                      llc_mem_rsp_valid,
    input  logic                      llc_mem_rsp_ready,
    output logic [LINE_BITS-1:0]      llc_mem_rsp_line,
    output logic                      mem_err,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int CNT_W    = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    mem_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 wr_en;
    logic                 addr_oor;
    logic [IDX_BITS-1:0]  idx;
    logic [LINE_BITS-1:0] arr_line;
    logic                 arr_valid;

    // Size and protection carry no meaning for a full-line store.
    logic unused_req_attr;
    assign unused_req_attr = &{1'b0, llc_mem_req_hsize, llc_mem_req_hprot};

    assign accept   = (state == ST_IDLE) && llc_mem_req_valid && llc_mem_req_ready;
    assign wr_en    = accept && llc_mem_req_hwrite;
    assign idx      = llc_mem_req_addr[IDX_BITS-1:0];
    assign addr_oor = (llc_mem_req_addr >> IDX_BITS) != '0;

    llc_mem_array #(
        .DEPTH    (DEPTH),
        .LINE_BITS(LINE_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_line (llc_mem_req_line),
        .rd_idx  (idx),
        .rd_line (arr_line),
        .rd_valid(arr_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            llc_mem_req_ready <= 1'b1;
            llc_mem_rsp_valid <= 1'b0;
            llc_mem_rsp_line  <= '0;
            mem_err           <= 1'b0;
            rd_count          <= '0;
            wr_count          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (addr_oor)
                            mem_err <= 1'b1;
                        if (llc_mem_req_hwrite) begin
                            wr_count <= sat_inc(wr_count);
                        end else begin
                            rd_count          <= sat_inc(rd_count);
                            llc_mem_rsp_line  <= arr_valid ? arr_line : '0;
                            llc_mem_req_ready <= 1'b0;
                            if (LATENCY == 0) begin
                                state             <= ST_RESP;
                                llc_mem_rsp_valid <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                                cnt   <= CNT_INIT;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state             <= ST_RESP;
                        llc_mem_rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (llc_mem_rsp_ready) begin
                        state             <= ST_IDLE;
                        llc_mem_rsp_valid <= 1'b0;
                        llc_mem_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state             <= ST_IDLE;
                    llc_mem_rsp_valid <= 1'b0;
                    llc_mem_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_mem_responder.sv
// Self-checking bench for llc_mem_responder: a default (LATENCY=4) instance and a
// LATENCY=0 instance, compared against a line-array reference model.
module tb_llc_mem_responder;

    localparam int LAT   = 4;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         a_req_valid = 0, a_req_ready, a_hwrite = 0;
    logic [2:0]   a_hsize = 3'd4;
    logic [1:0]   a_hprot = 2'd0;
    logic [27:0]  a_addr = '0;
    logic [127:0] a_line = '0;
    logic         a_rsp_valid, a_rsp_ready = 0;
    logic [127:0] a_rsp_line;
    logic         a_err;
    logic [31:0]  a_rd_count, a_wr_count;

    logic         b_req_valid = 0, b_req_ready, b_hwrite = 0;
    logic [27:0]  b_addr = '0;
    logic [127:0] b_line = '0;
    logic         b_rsp_valid, b_rsp_ready = 0;
    logic [127:0] b_rsp_line;
    logic         b_err;
    logic [31:0]  b_rd_count, b_wr_count;

    llc_mem_responder #(.LINE_ADDR_BITS(28), .LINE_BITS(128), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(a_req_valid), .llc_mem_req_ready(a_req_ready),
        .llc_mem_req_hwrite(a_hwrite), .llc_mem_req_hsize(a_hsize), .llc_mem_req_hprot(a_hprot),
        .llc_mem_req_addr(a_addr), .llc_mem_req_line(a_line),
        .llc_mem_rsp_valid(a_rsp_valid), .llc_mem_rsp_ready(a_rsp_ready), .llc_mem_rsp_line(a_rsp_line),
        .mem_err(a_err), .rd_count(a_rd_count), .wr_count(a_wr_count)
    );

    llc_mem_responder #(.LINE_ADDR_BITS(28), .LINE_BITS(128), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .llc_mem_req_valid(b_req_valid), .llc_mem_req_ready(b_req_ready),
        .llc_mem_req_hwrite(b_hwrite), .llc_mem_req_hsize(a_hsize), .llc_mem_req_hprot(a_hprot),
        .llc_mem_req_addr(b_addr), .llc_mem_req_line(b_line),
        .llc_mem_rsp_valid(b_rsp_valid), .llc_mem_rsp_ready(b_rsp_ready), .llc_mem_rsp_line(b_rsp_line),
        .mem_err(b_err), .rd_count(b_rd_count), .wr_count(b_wr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: only lines written since reset exist; everything else reads as zero.
    logic [127:0] mdl_mem [int];
    int           mdl_rd = 0, mdl_wr = 0;
    bit           mdl_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_rd_count"}, a_rd_count, mdl_rd);
        check({tag, "_wr_count"}, a_wr_count, mdl_wr);
        check({tag, "_mem_err"}, a_err, mdl_err);
    endtask

    // Each task below is entered and left just after a falling edge.
    task automatic do_write(input logic [27:0] addr, input logic [127:0] data);
        check("wr_req_ready", a_req_ready, 1'b1);
        a_req_valid = 1; a_hwrite = 1; a_addr = addr; a_line = data;
        @(negedge clk);
        a_req_valid = 0; a_hwrite = 0;
        mdl_mem[int'(addr % DEPTH)] = data;
        mdl_wr++;
        if (addr >= DEPTH) mdl_err = 1;
        check("wr_no_rsp", a_rsp_valid, 1'b0);
        check("wr_stays_idle", a_req_ready, 1'b1);
        check_stats("wr");
    endtask

    task automatic do_read(input logic [27:0] addr, input int stall);
        logic [127:0] exp;
        int idx;
        idx = int'(addr % DEPTH);
        exp = mdl_mem.exists(idx) ? mdl_mem[idx] : 128'd0;
        check("rd_req_ready", a_req_ready, 1'b1);
        a_req_valid = 1; a_hwrite = 0; a_addr = addr; a_rsp_ready = 0;
        @(negedge clk);
        a_req_valid = 0;
        mdl_rd++;
        if (addr >= DEPTH) mdl_err = 1;
        for (int i = 0; i < LAT; i++) begin
            check("rd_early_valid", a_rsp_valid, 1'b0);
            check("rd_busy_ready", a_req_ready, 1'b0);
            @(negedge clk);
        end
        check("rd_latency_valid", a_rsp_valid, 1'b1);
        check("rd_line", a_rsp_line, exp);
        check_stats("rd");
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", a_rsp_valid, 1'b1);
            check("stall_line", a_rsp_line, exp);
            check("stall_ready", a_req_ready, 1'b0);
        end
        a_rsp_ready = 1;
        @(negedge clk);
        a_rsp_ready = 0;
        check("hs_valid_drop", a_rsp_valid, 1'b0);
        check("hs_idle_ready", a_req_ready, 1'b1);
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [27:0] rand_addr();
        logic [27:0] a;
        a = 28'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0)
            a = a | (28'($urandom_range(1, 100)) << 10);
        return a;
    endfunction

    initial begin
        logic [127:0] line_a;
        logic [127:0] line_b;

        repeat (3) @(negedge clk);
        check("rst_req_ready", a_req_ready, 1'b1);
        check("rst_rsp_valid", a_rsp_valid, 1'b0);
        check("rst_rsp_line", a_rsp_line, 128'd0);
        check_stats("rst");
        check("rst0_rsp_valid", b_rsp_valid, 1'b0);
        rst = 1;
        @(negedge clk);

        // Unwritten line reads as zero after LATENCY+1 cycles.
        do_read(28'h5, 0);

        // Write then read back the same line on the very next edge.
        do_write(28'h10, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        do_read(28'h10, 0);

        // Backpressure: response held ten cycles.
        do_read(28'h10, 10);

        // Out-of-range write aliases to the low index and sets the sticky error.
        line_a = rand_line();
        do_write(28'(DEPTH + 3), line_a);
        do_read(28'h3, 0);
        do_write(28'h7, rand_line());
        do_read(28'h7, 1);
        check("err_sticky", a_err, 1'b1);

        // Randomized mix of reads and writes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), rand_line());
            else
                do_read(rand_addr(), int'($urandom_range(0, 3)));
        end

        // LATENCY=0 instance: response in the cycle after accept.
        line_b = rand_line();
        b_req_valid = 1; b_hwrite = 1; b_addr = 28'h9; b_line = line_b;
        @(negedge clk);
        b_hwrite = 0; b_rsp_ready = 1;
        check("l0_wr_no_rsp", b_rsp_valid, 1'b0);
        @(negedge clk);
        b_req_valid = 0;
        check("l0_rsp_valid", b_rsp_valid, 1'b1);
        check("l0_rsp_line", b_rsp_line, line_b);
        @(negedge clk);
        check("l0_idle_ready", b_req_ready, 1'b1);
        check("l0_rsp_drop", b_rsp_valid, 1'b0);

        // Back-to-back reads with the response always taken: one accept every two cycles.
        b_req_valid = 1; b_addr = 28'(($urandom_range(0, 15)));
        for (int i = 0; i < 20; i++) begin
            check("l0_b2b_ready", b_req_ready, (i % 2) == 0);
            check("l0_b2b_valid", b_rsp_valid, (i % 2) == 1);
            @(negedge clk);
        end
        b_req_valid = 0; b_rsp_ready = 0;
        check("l0_rd_count", b_rd_count, 32'd11);
        check("l0_wr_count", b_wr_count, 32'd1);
        check("l0_err", b_err, 1'b0);

        // Reset in the middle of a read wait aborts the read.
        do_write(28'h20, rand_line());
        a_req_valid = 1; a_hwrite = 0; a_addr = 28'h20;
        @(negedge clk);
        a_req_valid = 0;
        @(negedge clk);
        check("pre_rst_busy", a_req_ready, 1'b0);
        rst = 0;
        #1;
        mdl_mem.delete();
        mdl_rd = 0; mdl_wr = 0; mdl_err = 0;
        check("midrst_valid", a_rsp_valid, 1'b0);
        check("midrst_ready", a_req_ready, 1'b1);
        check_stats("midrst");
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", a_rsp_valid, 1'b0);
            check("post_rst_ready", a_req_ready, 1'b1);
        end
        do_read(28'h20, 0);
        do_read(28'h10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
